csi_raw8_unpack: RTL and testbench

Downstream stage of `csi_rx_ice40` in the `word_clk` domain. Takes the receiver's 32-bit RAW8 payload words (4 pixels per word, two lanes) and buffers them in a word FIFO. It serialises them into a one-pixel-per-cycle stream with valid/ready handshake, line/frame markers and x/y coordinates. It feeds display, preview and statistics logic that cannot accept 32-bit bursts.

---
 rtl/csi_pix_pkg.sv | 14 +
 rtl/csi_word_fifo.sv | 60 ++++++
 rtl/csi_raw8_unpack.sv | 156 +++++++++++++++
 tb/tb_csi_raw8_unpack.sv | 353 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/csi_pix_pkg.sv
// Shared pixel-path constants and the RAW8 byte-order helper for the CSI unpacker.
package csi_pix_pkg;

  localparam int RAW8_PER_WORD = 4;
  localparam int ENTRY_W       = 33;

  // Byte 0 in bits [7:0] is the first pixel on the wire.
  function automatic logic [7:0] raw8_byte(input logic [31:0] word, input logic [1:0] idx);
    logic [31:0] shifted;
    shifted = word >> {idx, 3'b000};
    return shifted[7:0];
  endfunction

endpackage

// File: rtl/csi_word_fifo.sv
// Word FIFO of {last, data} entries: EBR-style array with a registered read feeding
// a first-word-fall-through output register; occupancy counts that register too.
module csi_word_fifo
  import csi_pix_pkg::*;
#(
  parameter int DEPTH = 512
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [ENTRY_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [ENTRY_W-1:0] rd_data,
  output logic               rd_valid,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW:0]        wptr_reg;
  logic [AW:0]        rptr_reg;
  logic [AW:0]        used;
  logic               pop;
  logic               wr_ok;
  logic               mem_nonempty;
  logic               load;

  assign used         = (wptr_reg - rptr_reg) + (AW+1)'(rd_valid);
  assign full         = (used == (AW+1)'(DEPTH));
  assign empty        = (used == '0);
  assign pop          = rd_en && rd_valid;
  // A pop on the same edge frees a slot, so a write into a full FIFO still lands.
  assign wr_ok        = wr_en && (!full || pop);
  assign mem_nonempty = (wptr_reg != rptr_reg);
  assign load         = mem_nonempty && (!rd_valid || pop);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_reg[AW-1:0]] <= wr_data;
    if (load)  rd_data <= mem[rptr_reg[AW-1:0]];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_reg <= '0;
      rptr_reg <= '0;
      rd_valid <= 1'b0;
    end else begin
      if (wr_ok) wptr_reg <= wptr_reg + 1'b1;
      if (load) begin
        rptr_reg <= rptr_reg + 1'b1;
        rd_valid <= 1'b1;
      end else if (pop) begin
        rd_valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/csi_raw8_unpack.sv
// RAW8 word-to-pixel serialiser with line/frame markers and x/y coordinates.
// Optional crop window enabled by defining CSI_UNPACK_CROP_EN.
module csi_raw8_unpack
  import csi_pix_pkg::*;
#(
  parameter int FIFO_DEPTH = 512,
  parameter int XW         = 12,
  parameter int YW         = 12,
  parameter int CROP_X0    = 0,
  parameter int CROP_Y0    = 0,
  parameter int CROP_W     = 640,
  parameter int CROP_H     = 480
) (
  input  logic          word_clk,
  input  logic          areset,
  input  logic [31:0]   payload_data,
  input  logic          payload_enable,
  input  logic          in_line,
  input  logic          in_frame,
  output logic [7:0]    pix_data,
  output logic          pix_valid,
  input  logic          pix_ready,
  output logic [XW-1:0] pix_x,
  output logic [YW-1:0] pix_y,
  output logic          pix_sol,
  output logic          pix_eol,
  output logic          pix_sof,
  output logic          overflow
);

`ifdef CSI_UNPACK_CROP_EN
  localparam bit CROP_ON = 1'b1;
`else
  localparam bit CROP_ON = 1'b0;
`endif
  localparam logic [1:0] LAST_IDX = 2'(RAW8_PER_WORD - 1);

  logic [31:0]        stg_data_reg;
  logic               stg_valid_reg;
  logic               stg_last_reg;
  logic               in_line_reg;
  logic               in_frame_reg;
  logic [1:0]         idx_reg;
  logic [XW-1:0]      x_reg;
  logic [YW-1:0]      y_reg;
  logic               sof_pend_reg;
  logic               overflow_reg;

  logic               line_fall;
  logic               frame_rise;
  logic               wr_en;
  logic               wr_last;
  logic [ENTRY_W-1:0] head;
  logic               head_valid;
  logic               fifo_full;
  logic               fifo_empty;
  logic               last_pix;
  logic               in_window;
  logic               show;
  logic               consume;
  logic               pop;
  logic               drop;
  logic [31:0]        x_abs;
  logic [31:0]        y_abs;

  assign line_fall  = in_line_reg && !in_line;
  assign frame_rise = in_frame && !in_frame_reg;
  // stg_last_reg marks a word that arrived together with the in_line fall.
  assign wr_en      = stg_valid_reg && (payload_enable || line_fall || stg_last_reg);
  assign wr_last    = stg_last_reg || (line_fall && !payload_enable);

  always_ff @(posedge word_clk or posedge areset) begin
    if (areset) begin
      stg_data_reg  <= '0;
      stg_valid_reg <= 1'b0;
      stg_last_reg  <= 1'b0;
      in_line_reg   <= 1'b0;
      in_frame_reg  <= 1'b0;
    end else begin
      in_line_reg  <= in_line;
      in_frame_reg <= in_frame;
      if (payload_enable) begin
        stg_data_reg  <= payload_data;
        stg_valid_reg <= 1'b1;
        stg_last_reg  <= line_fall;
      end else if (wr_en) begin
        stg_valid_reg <= 1'b0;
        stg_last_reg  <= 1'b0;
      end
    end
  end

  csi_word_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk      (word_clk),
    .rst      (areset),
    .wr_en    (wr_en),
    .wr_data  ({wr_last, stg_data_reg}),
    .rd_en    (pop),
    .rd_data  (head),
    .rd_valid (head_valid),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Window test as unsigned offset so the left edge needs no separate >= compare.
  assign x_abs     = 32'(x_reg);
  assign y_abs     = 32'(y_reg);
  assign in_window = !CROP_ON ||
                     (((x_abs - 32'(CROP_X0)) < 32'(CROP_W)) &&
                      ((y_abs - 32'(CROP_Y0)) < 32'(CROP_H)));
  assign last_pix  = head[ENTRY_W-1] && (idx_reg == LAST_IDX);
  assign show      = head_valid && in_window;
  assign consume   = head_valid && (pix_ready || !in_window);
  assign pop       = consume && (idx_reg == LAST_IDX);
  assign drop      = wr_en && fifo_full && !pop;

  always_ff @(posedge word_clk or posedge areset) begin
    if (areset) begin
      idx_reg      <= '0;
      x_reg        <= '0;
      y_reg        <= '0;
      sof_pend_reg <= 1'b0;
      overflow_reg <= 1'b0;
    end else begin
      if (frame_rise) overflow_reg <= drop;
      else if (drop)  overflow_reg <= 1'b1;

      if (frame_rise && fifo_empty) begin
        y_reg        <= '0;
        sof_pend_reg <= 1'b0;
      end else begin
        if (frame_rise) sof_pend_reg <= 1'b1;
        if (consume) begin
          idx_reg <= idx_reg + 2'd1;
          if (last_pix) begin
            x_reg        <= '0;
            y_reg        <= (sof_pend_reg || frame_rise) ? '0 : y_reg + YW'(1);
            sof_pend_reg <= 1'b0;
          end else begin
            x_reg <= x_reg + XW'(1);
          end
        end
      end
    end
  end

  assign pix_valid = show;
  assign pix_data  = show ? raw8_byte(head[31:0], idx_reg) : 8'h00;
  assign pix_x     = x_reg;
  assign pix_y     = y_reg;
  assign pix_sol   = show && (CROP_ON ? (x_abs == 32'(CROP_X0)) : (x_reg == '0));
  assign pix_eol   = show && (CROP_ON ? (x_abs == 32'(CROP_X0 + CROP_W - 1)) : last_pix);
  assign pix_sof   = pix_sol && (CROP_ON ? (y_abs == 32'(CROP_Y0)) : (y_reg == '0));
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_csi_raw8_unpack.sv
// Bench for csi_raw8_unpack: line-level pixel model, per-cycle compare, directed scenarios.
module tb_csi_raw8_unpack;

  localparam int DEPTH = 4;
  localparam int CX0 = 2, CW = 4, CY0 = 0, CH = 1;
`ifdef CSI_UNPACK_CROP_EN
  localparam bit CROP = 1'b1;
`else
  localparam bit CROP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] payload_data;
  logic        payload_enable;
  logic        in_line;
  logic        in_frame;
  logic [7:0]  pix_data;
  logic        pix_valid;
  logic        pix_ready;
  logic [11:0] pix_x;
  logic [11:0] pix_y;
  logic        pix_sol, pix_eol, pix_sof, overflow;

  csi_raw8_unpack #(
    .FIFO_DEPTH(DEPTH), .XW(12), .YW(12),
    .CROP_X0(CX0), .CROP_Y0(CY0), .CROP_W(CW), .CROP_H(CH)
  ) dut (
    .word_clk(clk), .areset(areset), .payload_data(payload_data),
    .payload_enable(payload_enable), .in_line(in_line), .in_frame(in_frame),
    .pix_data(pix_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
    .pix_x(pix_x), .pix_y(pix_y), .pix_sol(pix_sol), .pix_eol(pix_eol),
    .pix_sof(pix_sof), .overflow(overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    int         x;
    int         y;
    bit         sol;
    bit         eol;
    bit         sof;
  } pix_t;

  pix_t        exp_q[$];
  pix_t        got[$];
  logic [31:0] line_words[$];
  int          checks = 0;
  int          failures = 0;
  int          mx = 0;
  int          my = 0;
  bit          bp_mode = 1'b0;
  logic        ready_level = 1'b1;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  // Model: each word yields four pixels at consecutive columns; the line's last byte ends the row.
  task automatic model_word(input logic [31:0] w, input bit last);
    for (int b = 0; b < 4; b++) begin
      pix_t p;
      bit   lst;
      lst  = last && (b == 3);
      p.d  = w[8*b +: 8];
      p.x  = mx;
      p.y  = my;
      if (CROP) begin
        if (mx >= CX0 && mx < CX0 + CW && my >= CY0 && my < CY0 + CH) begin
          p.sol = (mx == CX0);
          p.eol = (mx == CX0 + CW - 1);
          p.sof = p.sol && (my == CY0);
          exp_q.push_back(p);
        end
      end else begin
        p.sol = (mx == 0);
        p.eol = lst;
        p.sof = (mx == 0) && (my == 0);
        exp_q.push_back(p);
      end
      if (lst) begin
        mx = 0;
        my++;
      end else begin
        mx++;
      end
    end
  endtask

  task automatic send_line;
    in_line = 1'b1;
    for (int i = 0; i < line_words.size(); i++) begin
      payload_data   = line_words[i];
      payload_enable = 1'b1;
      model_word(line_words[i], i == line_words.size() - 1);
      tick;
      payload_enable = 1'b0;
      repeat (3) tick;
    end
    in_line = 1'b0;
    tick;
    tick;
  endtask

  task automatic drain(input string name, input int bound);
    int k;
    k = 0;
    while (exp_q.size() != 0 && k < bound) begin
      tick;
      k++;
    end
    check({name, "_drain_left"}, 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  // Frame start only ever issued while the bench's model is between lines.
  task automatic frame_start;
    in_frame = 1'b0;
    tick;
    in_frame = 1'b1;
    tick;
    my = 0;
  endtask

  initial begin
    pix_ready = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      pix_ready = bp_mode ? ~pix_ready : ready_level;
    end
  end

  // Per-cycle compare against the model plus hold-stability under backpressure.
  initial begin
    pix_t prev;
    bit   prev_stall;
    prev_stall = 1'b0;
    prev = '{d: 8'h00, x: 0, y: 0, sol: 1'b0, eol: 1'b0, sof: 1'b0};
    forever begin
      @(negedge clk);
      if (areset) begin
        prev_stall = 1'b0;
      end else begin
        pix_t cur;
        cur.d = pix_data; cur.x = int'(pix_x); cur.y = int'(pix_y);
        cur.sol = pix_sol; cur.eol = pix_eol; cur.sof = pix_sof;
        if (prev_stall) begin
          checks++;
          if (!pix_valid || cur != prev) begin
            failures++;
            $display("FAIL hold: got v=%b d=%h sol=%b eol=%b sof=%b expected v=1 d=%h sol=%b eol=%b sof=%b",
                     pix_valid, cur.d, cur.sol, cur.eol, cur.sof, prev.d, prev.sol, prev.eol, prev.sof);
          end
        end
        if (pix_valid && pix_ready) begin
          got.push_back(cur);
          checks++;
          if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL pixel_unexpected: got d=%h x=%0d y=%0d expected no pixel", cur.d, cur.x, cur.y);
          end else begin
            pix_t e;
            e = exp_q.pop_front();
            if (cur != e) begin
              failures++;
              $display("FAIL pixel: got d=%h x=%0d y=%0d sol=%b eol=%b sof=%b expected d=%h x=%0d y=%0d sol=%b eol=%b sof=%b",
                       cur.d, cur.x, cur.y, cur.sol, cur.eol, cur.sof, e.d, e.x, e.y, e.sol, e.eol, e.sof);
            end
          end
        end
        prev_stall = pix_valid && !pix_ready;
        prev = cur;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int need;
    bit seen_valid;
    areset = 1'b1; payload_data = '0; payload_enable = 1'b0;
    in_line = 1'b0; in_frame = 1'b0;
    repeat (3) tick;
    check("reset_outputs",
          64'({pix_valid, pix_data, pix_x, pix_y, pix_sol, pix_eol, pix_sof, overflow}), 64'd0);
    areset = 1'b0;
    tick;
    in_frame = 1'b1;
    tick;
    tick;

    // One line, free-flowing sink
    got.delete();
    line_words = '{32'h03020100, 32'h07060504};
    send_line();
    drain("line1", 100);
    check("line1_count", 64'(got.size()), CROP ? 64'd4 : 64'd8);
    if (got.size() >= 4) begin
      check("line1_first_data", 64'(got[0].d), CROP ? 64'h02 : 64'h00);
      check("line1_first_marks", 64'({got[0].sol, got[0].eol, got[0].sof}), 64'b101);
      check("line1_first_x", 64'(got[0].x), CROP ? 64'd2 : 64'd0);
      check("line1_idx3_eol", 64'(got[3].eol), CROP ? 64'd1 : 64'd0);
    end
    if (!CROP && got.size() == 8) begin
      check("line1_last_data", 64'(got[7].d), 64'h07);
      check("line1_last_x", 64'(got[7].x), 64'd7);
      check("line1_last_eol", 64'(got[7].eol), 64'd1);
    end

    // Same line with the sink toggling ready each cycle
    got.delete();
    bp_mode = 1'b1;
    line_words = '{32'h03020100, 32'h07060504};
    send_line();
    drain("bp", 200);
    bp_mode = 1'b0;
    ready_level = 1'b1;
    tick;
    check("bp_count", 64'(got.size()), CROP ? 64'd0 : 64'd8);
    if (!CROP && got.size() == 8) begin
      check("bp_data5", 64'(got[5].d), 64'h05);
      check("bp_y", 64'(got[5].y), 64'd1);
    end

    // Frame sequencing: two lines, FE/FS, one line
    frame_start();
    got.delete();
    line_words = '{32'h13121110, 32'h17161514};
    send_line(); drain("fa", 100);
    line_words = '{32'h23222120, 32'h27262524};
    send_line(); drain("fb", 100);
    frame_start();
    line_words = '{32'h33323130, 32'h37363534};
    send_line(); drain("fc", 100);
    check("frame_count", 64'(got.size()), CROP ? 64'd8 : 64'd24);
    if (!CROP && got.size() == 24) begin
      check("frame_l0", 64'({got[0].y[3:0], got[0].sof}), 64'b0_0000_1);
      check("frame_l1", 64'({got[8].y[3:0], got[8].sol, got[8].sof}), 64'b0001_1_0);
      check("frame_l2", 64'({got[16].y[3:0], got[16].sof, got[16].d}), 64'({4'd0, 1'b1, 8'h30}));
    end
    if (CROP && got.size() == 8)
      check("frame_crop_l2", 64'({got[4].y[3:0], got[4].sof, got[4].d}), 64'({4'd0, 1'b1, 8'h32}));

    // FS while the serialiser is still busy: y clear is deferred to the eol
    got.delete();
    line_words = '{32'h43424140, 32'h47464544};
    send_line();
    frame_start();
    line_words = '{32'h53525150, 32'h57565554};
    send_line();
    drain("deferred", 100);
    check("deferred_count", 64'(got.size()), CROP ? 64'd4 : 64'd16);
    if (!CROP && got.size() == 16)
      check("deferred_y0", 64'({got[8].y[3:0], got[8].sof, got[8].d}), 64'({4'd0, 1'b1, 8'h50}));

    // Overflow with DEPTH=4: six words, sink stalled
    frame_start();
    ready_level = 1'b0;
    tick; tick;
    got.delete();
    in_line = 1'b1;
    line_words = '{32'h63626160, 32'h67666564, 32'h6b6a6968, 32'h6f6e6d6c, 32'h73727170, 32'h77767574};
    for (int i = 0; i < 6; i++) begin
      payload_data = line_words[i];
      payload_enable = 1'b1;
      tick;
      payload_enable = 1'b0;
      repeat (3) tick;
    end
    check("ovf_set", 64'(overflow), 64'd1);
    for (int i = 0; i < 4; i++) model_word(line_words[i], 1'b0);
    model_word(line_words[5], 1'b1);
    ready_level = 1'b1;
    repeat (30) tick;
    in_line = 1'b0;
    tick; tick;
    drain("ovf", 100);
    check("ovf_count", 64'(got.size()), CROP ? 64'd4 : 64'd20);
    if (!CROP && got.size() == 20)
      check("ovf_tail", 64'({got[16].d, got[19].d, got[19].eol}), 64'({8'h74, 8'h77, 1'b1}));
    if (CROP && got.size() == 4)
      check("ovf_crop_first", 64'(got[0].d), 64'h62);
    check("ovf_sticky", 64'(overflow), 64'd1);
    frame_start();
    check("ovf_clear", 64'(overflow), 64'd0);

    // Reset mid-line after three (crop: two) accepted pixels
    got.delete();
    need = CROP ? 2 : 3;
    in_line = 1'b1;
    payload_data = 32'ha3a2a1a0; payload_enable = 1'b1;
    model_word(32'ha3a2a1a0, 1'b0);
    tick;
    payload_enable = 1'b0;
    repeat (3) tick;
    payload_data = 32'hb3b2b1b0; payload_enable = 1'b1;
    tick;
    payload_enable = 1'b0;
    k = 0;
    while (got.size() < need && k < 50) begin
      tick;
      k++;
    end
    check("rst_pre_count", 64'(got.size()), 64'(need));
    areset = 1'b1;
    in_line = 1'b0;
    exp_q.delete();
    mx = 0;
    my = 0;
    @(negedge clk);
    check("rst_outputs",
          64'({pix_valid, pix_data, pix_x, pix_y, pix_sol, pix_eol, pix_sof, overflow}), 64'd0);
    tick;
    areset = 1'b0;
    seen_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick;
      if (pix_valid) seen_valid = 1'b1;
    end
    check("rst_fifo_empty", 64'(seen_valid), 64'd0);
    got.delete();
    line_words = '{32'h03020100, 32'h07060504};
    send_line();
    drain("after_rst", 100);
    if (got.size() > 0)
      check("after_rst_first", 64'({got[0].x[3:0], got[0].y[3:0], got[0].sof}),
            CROP ? 64'b0010_0000_1 : 64'b0000_0000_1);
    else
      check("after_rst_count", 64'(got.size()), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
